// File: rtl/cam_capture_decimate.sv
// ---------------------------------------------------------------------------
// cam_capture_decimate
//
// Camera front-end for an OV7670-style byte stream (RGB565, two bytes per
// pixel). Pairs bytes into pixels and keeps one pixel in every
// 2^DECIM_SHIFT columns and rows. Each kept pixel is presented with a
// one-cycle write strobe for the frame-buffer BRAM port.
//
// Ports:
//   clk25        camera pixel clock; all logic on the rising edge
//   reset        asynchronous, active-high reset
//   capture_en   level enable, sampled only when a frame starts
//   cam_vsync    camera VSYNC, high during vertical blanking
//   cam_href     camera HREF, high while line bytes are valid
//   cam_data     camera data byte
//   pixel        last kept RGB565 pixel {first byte, second byte}
//   pixel_we     one-cycle strobe for a kept pixel
//   frame_active high while a frame is being captured
//   frame_done   one-cycle pulse when a captured frame completes
//   frame_count  number of completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module cam_capture_decimate #(
    parameter int H_IN        = 640,
    parameter int V_IN        = 480,
    parameter int DECIM_SHIFT = 2
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] pixel,
    output logic        pixel_we,
    output logic        frame_active,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [9:0] X_LAST = 10'(H_IN - 1);
    localparam logic [9:0] Y_LIM  = 10'(V_IN);
    localparam logic [9:0] X_MASK = 10'((1 << DECIM_SHIFT) - 1);
    localparam logic [8:0] Y_MASK = 9'((1 << DECIM_SHIFT) - 1);
    localparam logic [8:0] Y_MAX  = 9'h1FF;

    // Registered camera inputs and their previous values for edge detection.
    logic       vsync_r;
    logic       vsync_d_r;
    logic       href_r;
    logic       href_d_r;
    logic [7:0] data_r;

    state_t     state_r;
    state_t     next_state_s;
    logic       enter_active_s;
    logic       leave_active_s;

    logic       vs_rise_s;
    logic       vs_fall_s;
    logic       href_fall_s;

    logic       phase_r;
    logic [7:0] hi_byte_r;
    logic [9:0] x_r;
    // Set once the last legal column has been completed; later pixels on
    // the same line are ignored without disturbing x.
    logic       x_full_r;
    logic [8:0] y_r;

    logic       keep_s;

    // Input capture stage: one register on every camera input plus history.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            vsync_r   <= 1'b0;
            vsync_d_r <= 1'b0;
            href_r    <= 1'b0;
            href_d_r  <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            vsync_r   <= cam_vsync;
            vsync_d_r <= vsync_r;
            href_r    <= cam_href;
            href_d_r  <= href_r;
            data_r    <= cam_data;
        end
    end

    // Edge detection on the registered synchronisation signals.
    always_comb begin
        vs_rise_s   = vsync_r & ~vsync_d_r;
        vs_fall_s   = ~vsync_r & vsync_d_r;
        href_fall_s = ~href_r & href_d_r;
    end

    // Frame state register.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame state next-state logic; capture_en matters only at frame start.
    always_comb begin
        next_state_s   = state_r;
        enter_active_s = 1'b0;
        leave_active_s = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (vs_rise_s) begin
                    next_state_s = ST_BLANK;
                end else begin
                    next_state_s = ST_SYNC;
                end
            end
            ST_BLANK: begin
                if (vs_fall_s && capture_en) begin
                    next_state_s   = ST_ACTIVE;
                    enter_active_s = 1'b1;
                end else begin
                    next_state_s = ST_BLANK;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise_s) begin
                    next_state_s   = ST_BLANK;
                    leave_active_s = 1'b1;
                end else begin
                    next_state_s = ST_ACTIVE;
                end
            end
            default: begin
                next_state_s = ST_SYNC;
            end
        endcase
    end

    // Keep decision for the pixel completing this cycle. A vsync rising
    // edge wins over a coincident second byte, so a partial pixel is lost.
    always_comb begin
        if ((state_r == ST_ACTIVE) && !vs_rise_s && href_r && phase_r &&
            !x_full_r && ({1'b0, y_r} < Y_LIM) &&
            ((x_r & X_MASK) == 10'd0) && ((y_r & Y_MASK) == 9'd0)) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
    end

    // Byte pairing, column/line counting and registered outputs.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            phase_r      <= 1'b0;
            hi_byte_r    <= 8'h00;
            x_r          <= 10'd0;
            x_full_r     <= 1'b0;
            y_r          <= 9'd0;
            pixel        <= 16'h0000;
            pixel_we     <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            pixel_we     <= 1'b0;
            frame_done   <= 1'b0;
            frame_active <= (next_state_s == ST_ACTIVE);
            if (enter_active_s) begin
                phase_r  <= 1'b0;
                x_r      <= 10'd0;
                x_full_r <= 1'b0;
                y_r      <= 9'd0;
            end else if (leave_active_s) begin
                phase_r     <= 1'b0;
                x_r         <= 10'd0;
                x_full_r    <= 1'b0;
                y_r         <= 9'd0;
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end else if (state_r == ST_ACTIVE) begin
                if (href_r) begin
                    if (!phase_r) begin
                        hi_byte_r <= data_r;
                        phase_r   <= 1'b1;
                    end else begin
                        phase_r <= 1'b0;
                        if (keep_s) begin
                            pixel    <= {hi_byte_r, data_r};
                            pixel_we <= 1'b1;
                        end
                        if (!x_full_r) begin
                            if (x_r == X_LAST) begin
                                x_full_r <= 1'b1;
                            end else begin
                                x_r <= x_r + 10'd1;
                            end
                        end
                    end
                end else begin
                    // Dropping href discards any dangling odd byte.
                    phase_r <= 1'b0;
                    if (href_fall_s) begin
                        x_r      <= 10'd0;
                        x_full_r <= 1'b0;
                        if (y_r != Y_MAX) begin
                            y_r <= y_r + 9'd1;
                        end
                    end
                end
            end else begin
                phase_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cam_capture_decimate.md
Name: cam_capture_decimate

Overview:
Camera front-end that turns the OV7670 byte stream (RGB565, two bytes per pixel, 640x480) into decimated 160x120 pixels with a single-cycle write strobe. It sits directly upstream of the frame-buffer address generator. Its pixel_we drives the generator's enable, and its frame_active drives the generator's active-low vsync input, so the address clears between frames. Pixel data goes to the frame-buffer BRAM write port.

Parameters:
H_IN, 640, input pixels per line
V_IN, 480, input lines per frame
DECIM_SHIFT, 2, log2 of decimation factor in both axes (4 -> 160x120)

Ports:
clk25  in  1  camera pixel clock (PCLK, 25 MHz); all logic on rising edge
reset  in  1  asynchronous, active-high reset
capture_en  in  1  allow capture of new frames (level)
cam_vsync  in  1  camera VSYNC, high during vertical blanking
cam_href  in  1  camera HREF, high while line bytes valid
cam_data  in  8  camera data byte
pixel  out  16  RGB565 pixel {first byte, second byte}
pixel_we  out  1  one-cycle strobe, pixel valid and kept by decimation
frame_active  out  1  high while a frame is being captured, low otherwise
frame_done  out  1  one-cycle pulse at end of a completed captured frame
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (async assert, sync release): state=SYNC, all counters 0, byte phase 0. pixel=0, pixel_we=0, frame_active=0, frame_done=0, frame_count=0.
- Inputs cam_vsync, cam_href and cam_data are registered once. Edge detection uses the registered value and its previous value. All decisions below use the registered values, so there is a fixed 1-cycle input latency.
- State machine:
  - SYNC: wait for a vsync rising edge, then go to BLANK. Any frame already in progress at reset or at the first enable is discarded.
  - BLANK: on a vsync falling edge, go to ACTIVE if capture_en=1; otherwise stay in BLANK.
  - ACTIVE: frame_active=1. On a vsync rising edge, go to BLANK, pulse frame_done for 1 cycle and increment frame_count.
  - capture_en is sampled only on the BLANK->ACTIVE transition. Deasserting it mid-frame does not abort the frame.
- In ACTIVE, byte phase toggles on each cycle with href=1:
  - Phase 0 latches the high byte.
  - Phase 1 completes the pixel.
  - Phase resets to 0 when href=0, so a dangling odd byte at the end of a line is discarded with no strobe.
- Column counter x (10 bits) increments on each completed pixel and clears at the href falling edge. It saturates at H_IN-1: pixels beyond H_IN are ignored and produce no strobe.
- Line counter y (9 bits) increments on each href falling edge and clears on entering ACTIVE. Lines with y>=V_IN produce no strobes.
- Keep rule: x[DECIM_SHIFT-1:0]==0 and y[DECIM_SHIFT-1:0]==0.
- For a kept pixel, pixel updates and pixel_we=1 in the cycle after the phase-1 byte is registered. pixel holds its value until the next kept pixel.
- pixel_we rate is at most 1 per 2*2^DECIM_SHIFT cycles, so it is never asserted on consecutive cycles.
- Strobes in a complete frame: (H_IN>>DECIM_SHIFT)*(V_IN>>DECIM_SHIFT) = 19200 by default.
- Vsync rising edge mid-line: the frame ends immediately, counters clear, and any pending partial pixel is dropped.
- frame_active is registered and falls in the same cycle frame_done pulses, so the downstream address clears before the next frame.
- Reset mid-frame: outputs clear immediately and state returns to SYNC. The next captured frame is the first one whose start is fully observed.

Test Plan:
- Reset, capture_en=1, 2 full 640x480 frames with incrementing bytes (rows start at 0 after an initial vsync high) -> frame 1 skipped only if it began before SYNC saw a vsync rising edge. Each captured frame gives exactly 19200 pixel_we, frame_done once per frame, frame_count=1 then 2.
- Line 0, bytes 0x12,0x34 at x=0, then 0x56,0x78 at x=1 -> pixel=0x1234 with pixel_we 1 cycle after the second byte. x=1 gives no strobe. Next strobe at x=4.
- Line carrying 641 pixels plus 1 odd byte -> 160 strobes for the line, no strobe for pixel 640 or the odd byte. The next line starts at phase 0.
- capture_en=0 at vsync falling, raised mid-frame -> no strobes and frame_active=0 that frame. The following frame is captured fully.
- Vsync rising at line 200, x=300 -> frame_done pulse, frame_active drops to 0, strobes stop. The count is lines 0..196 complete (50 rows x 160 = 8000) plus line 200 x=0..296 (75) = 8075.
- Assert reset at 10000 strobes in, release -> all outputs 0 at once. SYNC ignores the remainder of that frame, and the next full frame gives 19200 strobes.
